branch_unit: RTL and testbench

- Execute-stage control-transfer resolver. It is the producer side of the program counter's redirect interface: it drives branch_valid / branch_address into the PC.
- Evaluates conditional branches, jumps, calls and returns, and keeps a small return-address stack (RAS).
- Issues a one-cycle registered redirect pulse, then asserts flush for the younger in-flight instructions.
- Sits between the EX stage and the PC. It also drives pipeline squash.

---
 rtl/branch_pkg.sv | 11 +
 rtl/branch_unit_if.sv | 28 ++
 rtl/branch_ras.sv | 45 ++++
 rtl/branch_unit.sv | 91 +++++++++
 tb/tb_branch_unit.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared control-transfer encodings for the branch resolver.
package branch_pkg;
    localparam int BR_TYPE_W = 3;

    localparam logic [BR_TYPE_W-1:0] BR_JMP  = 3'b000;
    localparam logic [BR_TYPE_W-1:0] BR_BEQ  = 3'b001;
    localparam logic [BR_TYPE_W-1:0] BR_BNE  = 3'b010;
    localparam logic [BR_TYPE_W-1:0] BR_BLT  = 3'b011;
    localparam logic [BR_TYPE_W-1:0] BR_CALL = 3'b100;
    localparam logic [BR_TYPE_W-1:0] BR_RET  = 3'b101;
endpackage

// File: rtl/branch_unit_if.sv
// EX-stage request bundle and PC redirect / squash outputs.
interface branch_unit_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    import branch_pkg::*;

    logic                 br_req;
    logic [BR_TYPE_W-1:0] br_type;
    logic [ADDR_W-1:0]    pc_in;
    logic [ADDR_W-1:0]    target;
    logic [DATA_W-1:0]    op_a;
    logic [DATA_W-1:0]    op_b;
    logic                 branch_valid;
    logic [ADDR_W-1:0]    branch_address;
    logic                 flush;
    logic                 ras_err;

    modport master (
        input  br_req, br_type, pc_in, target, op_a, op_b,
        output branch_valid, branch_address, flush, ras_err
    );

    modport slave (
        output br_req, br_type, pc_in, target, op_a, op_b,
        input  branch_valid, branch_address, flush, ras_err
    );
endinterface

// File: rtl/branch_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module branch_ras #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PW-1:0]     ptr;
    logic [CW-1:0]     cnt;

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(DEPTH));
    assign top   = mem[ptr - PW'(1)];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full)
                cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            ptr <= ptr - PW'(1);
            cnt <= cnt - CW'(1);
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push)
            mem[ptr] <= data;
    end
endmodule

// File: rtl/branch_unit.sv
// EX-stage control-transfer resolver: registered PC redirect, flush window, RAS.
module branch_unit
    import branch_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int RAS_DEPTH    = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input logic           clk,
    input logic           reset,
    branch_unit_if.master bus
);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);

    logic [FW-1:0]     flush_cnt;
    logic              accept;
    logic              taken;
    logic [ADDR_W-1:0] next_addr;
    logic              push;
    logic              pop;
    logic              ras_empty;
    logic              ras_full;
    logic [ADDR_W-1:0] ras_top;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;

    assign a_s    = bus.op_a;
    assign b_s    = bus.op_b;
    assign accept = bus.br_req && (flush_cnt == '0);
    assign push   = accept && (bus.br_type == BR_CALL);
    assign pop    = accept && (bus.br_type == BR_RET);

    always_comb begin
        taken     = 1'b0;
        next_addr = bus.target;
        case (bus.br_type)
            BR_JMP, BR_CALL: taken = 1'b1;
            BR_BEQ:          taken = (bus.op_a == bus.op_b);
            BR_BNE:          taken = (bus.op_a != bus.op_b);
            BR_BLT:          taken = (a_s < b_s);
            BR_RET: begin
                taken     = 1'b1;
                next_addr = ras_empty ? '0 : ras_top;
            end
            default:         taken = 1'b0;
        endcase
    end

    branch_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .data  (bus.pc_in + ADDR_W'(1)),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            flush_cnt <= '0;
        end else begin
            valid_q <= accept && taken;
            if (accept && taken) begin
                addr_q    <= next_addr;
                flush_cnt <= FW'(FLUSH_CYCLES);
            end else if (flush_cnt != '0) begin
                flush_cnt <= flush_cnt - FW'(1);
            end
            if ((push && ras_full) || (pop && ras_empty))
                err_q <= 1'b1;
        end
    end

    assign bus.branch_valid   = valid_q;
    assign bus.branch_address = addr_q;
    assign bus.flush          = (flush_cnt != '0);
    assign bus.ras_err        = err_q;
endmodule

// File: tb/tb_branch_unit.sv
// Directed self-checking bench for branch_unit.
module tb_branch_unit;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   nchk = 0;
    int   nfail = 0;

    branch_unit_if #(.ADDR_W(11), .DATA_W(16)) bus ();

    branch_unit #(
        .ADDR_W       (11),
        .DATA_W       (16),
        .RAS_DEPTH    (4),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Present one request for a single edge; returns at edge+1.
    task automatic issue(input logic [2:0] t, input logic [10:0] pc,
                         input logic [10:0] tg, input logic [15:0] a,
                         input logic [15:0] b);
        @(negedge clk);
        bus.br_req  = 1'b1;
        bus.br_type = t;
        bus.pc_in   = pc;
        bus.target  = tg;
        bus.op_a    = a;
        bus.op_b    = b;
        @(posedge clk);
        #1;
        bus.br_req = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Taken redirect: checks pulse, address and the 2-cycle flush window.
    task automatic expect_redirect(input string nm, input logic [10:0] ea);
        nchk++;
        if (bus.branch_valid !== 1'b1 || bus.branch_address !== ea) begin
            nfail++;
            $display("FAIL %s pulse: valid=%b addr=%h want valid=1 addr=%h",
                     nm, bus.branch_valid, bus.branch_address, ea);
        end
        nchk++;
        if (bus.flush !== 1'b1) begin
            nfail++;
            $display("FAIL %s flush0: got %b want 1", nm, bus.flush);
        end
        step();
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b1) begin
            nfail++;
            $display("FAIL %s cyc1: valid=%b flush=%b want valid=0 flush=1",
                     nm, bus.branch_valid, bus.flush);
        end
        step();
        nchk++;
        if (bus.flush !== 1'b0) begin
            nfail++;
            $display("FAIL %s flush_end: got %b want 0", nm, bus.flush);
        end
    endtask

    task automatic test_reset();
        bus.br_req  = 1'b0;
        bus.br_type = '0;
        bus.pc_in   = '0;
        bus.target  = '0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b0 ||
            bus.ras_err !== 1'b0 || bus.branch_address !== 11'h000) begin
            nfail++;
            $display("FAIL reset: valid=%b flush=%b err=%b addr=%h want 0/0/0/000",
                     bus.branch_valid, bus.flush, bus.ras_err,
                     bus.branch_address);
        end
    endtask

    task automatic test_beq();
        issue(BR_BEQ, 11'h040, 11'h155, 16'h1234, 16'h1234);
        expect_redirect("beq_taken", 11'h155);
        issue(BR_BEQ, 11'h041, 11'h0AA, 16'h0001, 16'h0002);
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b0 ||
            bus.branch_address !== 11'h155) begin
            nfail++;
            $display("FAIL beq_not_taken: valid=%b flush=%b addr=%h want 0/0/155",
                     bus.branch_valid, bus.flush, bus.branch_address);
        end
    endtask

    task automatic test_blt();
        issue(BR_BLT, 11'h050, 11'h020, 16'hFFFF, 16'h0001);
        expect_redirect("blt_taken", 11'h020);
        issue(BR_BLT, 11'h051, 11'h030, 16'h0001, 16'hFFFF);
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b0 ||
            bus.branch_address !== 11'h020) begin
            nfail++;
            $display("FAIL blt_not_taken: valid=%b flush=%b addr=%h want 0/0/020",
                     bus.branch_valid, bus.flush, bus.branch_address);
        end
        issue(BR_BNE, 11'h052, 11'h033, 16'h0005, 16'h0005);
        nchk++;
        if (bus.branch_valid !== 1'b0) begin
            nfail++;
            $display("FAIL bne_not_taken: valid=%b want 0", bus.branch_valid);
        end
        issue(3'b110, 11'h053, 11'h044, 16'h0000, 16'h0000);
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b0) begin
            nfail++;
            $display("FAIL reserved: valid=%b flush=%b want 0/0",
                     bus.branch_valid, bus.flush);
        end
    endtask

    task automatic test_call_ret();
        issue(BR_CALL, 11'h010, 11'h100, '0, '0);
        expect_redirect("call1", 11'h100);
        issue(BR_CALL, 11'h105, 11'h200, '0, '0);
        expect_redirect("call2", 11'h200);
        issue(BR_RET, 11'h203, 11'h000, '0, '0);
        expect_redirect("ret1", 11'h106);
        issue(BR_RET, 11'h107, 11'h000, '0, '0);
        expect_redirect("ret2", 11'h011);
        nchk++;
        if (bus.ras_err !== 1'b0) begin
            nfail++;
            $display("FAIL nest_err: got %b want 0", bus.ras_err);
        end
    endtask

    task automatic test_wrap();
        issue(BR_CALL, 11'h7FF, 11'h123, '0, '0);
        expect_redirect("call_wrap", 11'h123);
        issue(BR_RET, 11'h124, 11'h000, '0, '0);
        expect_redirect("ret_wrap", 11'h000);
        nchk++;
        if (bus.ras_err !== 1'b0) begin
            nfail++;
            $display("FAIL wrap_err: got %b want 0", bus.ras_err);
        end
    endtask

    task automatic test_overflow();
        logic [10:0] pc;
        logic [10:0] want;
        for (int i = 0; i < 5; i++) begin
            pc = 11'h020 + 11'(i);
            issue(BR_CALL, pc, 11'h400, '0, '0);
            expect_redirect("ovf_call", 11'h400);
        end
        nchk++;
        if (bus.ras_err !== 1'b1) begin
            nfail++;
            $display("FAIL ovf_err: got %b want 1", bus.ras_err);
        end
        for (int i = 0; i < 4; i++) begin
            want = 11'h025 - 11'(i);
            issue(BR_RET, 11'h400, 11'h000, '0, '0);
            expect_redirect("ovf_ret", want);
        end
        issue(BR_RET, 11'h400, 11'h555, '0, '0);
        expect_redirect("underflow", 11'h000);
        nchk++;
        if (bus.ras_err !== 1'b1) begin
            nfail++;
            $display("FAIL unf_err: got %b want 1", bus.ras_err);
        end
    endtask

    task automatic test_back_to_back();
        issue(BR_JMP, 11'h000, 11'h300, '0, '0);
        nchk++;
        if (bus.branch_valid !== 1'b1 || bus.branch_address !== 11'h300) begin
            nfail++;
            $display("FAIL jmp: valid=%b addr=%h want 1/300",
                     bus.branch_valid, bus.branch_address);
        end
        bus.br_req  = 1'b1;
        bus.br_type = BR_BNE;
        bus.target  = 11'h3AA;
        bus.op_a    = 16'h0001;
        bus.op_b    = 16'h0002;
        step();
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b1) begin
            nfail++;
            $display("FAIL mask1: valid=%b flush=%b want 0/1",
                     bus.branch_valid, bus.flush);
        end
        step();
        bus.br_req = 1'b0;
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.branch_address !== 11'h300) begin
            nfail++;
            $display("FAIL mask2: valid=%b addr=%h want 0/300",
                     bus.branch_valid, bus.branch_address);
        end
        step();
        nchk++;
        if (bus.branch_valid !== 1'b0 || bus.flush !== 1'b0) begin
            nfail++;
            $display("FAIL mask3: valid=%b flush=%b want 0/0",
                     bus.branch_valid, bus.flush);
        end
        issue(BR_BNE, 11'h301, 11'h3AA, 16'h0001, 16'h0002);
        expect_redirect("bne_after", 11'h3AA);
    endtask

    task automatic test_reset_mid_flush();
        issue(BR_JMP, 11'h000, 11'h155, '0, '0);
        #2;
        reset = 1'b1;
        #1;
        nchk++;
        if (bus.flush !== 1'b0 || bus.branch_valid !== 1'b0 ||
            bus.branch_address !== 11'h000) begin
            nfail++;
            $display("FAIL rst_mid: flush=%b valid=%b addr=%h want 0/0/000",
                     bus.flush, bus.branch_valid, bus.branch_address);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        nchk++;
        if (bus.flush !== 1'b0 || bus.ras_err !== 1'b0) begin
            nfail++;
            $display("FAIL rst_after: flush=%b err=%b want 0/0",
                     bus.flush, bus.ras_err);
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_blt();
        test_call_ret();
        test_wrap();
        test_overflow();
        test_back_to_back();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 nchk, nfail);
        $finish;
    end
endmodule
